// File: rtl/reg_file_pkg.sv
// Shared constants and types for the MIPS architectural register file.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/reg_wr_decoder.sv
// Write-side one-hot decoder: the demux counterpart of the read-port muxes.
// Bit 0 is always low so register 0 can never be written.
module reg_wr_decoder
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(1<<ADDR_W)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
    onehot[0] = 1'b0;
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 MIPS register file: one synchronous write port, two combinational
// read ports, r0 hardwired to zero. Define REG_FILE_BYPASS_EN for write-through.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NUM = 1 << ADDR_W;

  logic [NUM-1:0]    wr_en;
  logic [DATA_W-1:0] regs [1:NUM-1];
  logic              unused_wr_en0;

  reg_wr_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .en     (we),
    .addr   (waddr),
    .onehot (wr_en)
  );

  // r0 has no storage, so its decoder output has nowhere to go.
  assign unused_wr_en0 = wr_en[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM; i++) begin
        if (wr_en[i]) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  // Read muxes: address 0 matches no stored register and falls through to 0.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    for (int i = 1; i < NUM; i++) begin
      if (raddr1 == ADDR_W'(i)) rdata1 = regs[i];
      if (raddr2 == ADDR_W'(i)) rdata2 = regs[i];
    end
`ifdef REG_FILE_BYPASS_EN
    // Forwarding is held off during reset so every address reads 0 then.
    if (rst_n && we && (waddr != '0)) begin
      if (raddr1 == waddr) rdata1 = wdata;
      if (raddr2 == waddr) rdata2 = wdata;
    end
`endif
  end

endmodule
